// File: rtl/ir_sensor_conditioner.sv
// IR reflectance front end: 2-flop synchroniser, per-channel debounce, warm-up valid flag and line-lost timer.
// Optional macro IR_LAST_SIDE_HOLD_EN: while line_lost, output holds the last non-zero debounced value.
module ir_sensor_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int LOST_TIMEOUT    = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] ir_raw,
  output logic [1:0] ir_sensor_data,
  output logic       data_valid,
  output logic       change_pulse,
  output logic       line_lost
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LW = $clog2(LOST_TIMEOUT + 1);
  localparam int WW = $clog2(DEBOUNCE_CYCLES + 2);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [WW-1:0] WARM_LAST = WW'(DEBOUNCE_CYCLES + 1);
  localparam logic [LW-1:0] LOST_MAX  = LW'(LOST_TIMEOUT);

  logic [1:0]    s1_q, s2_q;
  logic [1:0]    stable_q, stable_d;
  logic [WW-1:0] warm_q, warm_d;
  logic          valid_q, valid_d;
  logic [LW-1:0] timer_q, timer_d;
  logic          lost_q, lost_d;
  logic [1:0]    out_q, out_d;
  logic          change_q, change_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= 2'b00;
      s2_q <= 2'b00;
    end else begin
      s1_q <= ir_raw;
      s2_q <= s1_q;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      logic [DW-1:0] cnt_q, cnt_d;
      logic          bit_q, bit_d;

      // Counter runs only while s2 disagrees; acceptance happens on the
      // DEBOUNCE_CYCLES-th consecutive disagreeing edge.
      always_comb begin
        cnt_d = '0;
        bit_d = bit_q;
        if (s2_q[gi] != bit_q) begin
          if (cnt_q == DB_LAST) begin
            bit_d = s2_q[gi];
          end else begin
            cnt_d = cnt_q + DW'(1);
          end
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cnt_q <= '0;
          bit_q <= 1'b0;
        end else begin
          cnt_q <= cnt_d;
          bit_q <= bit_d;
        end
      end

      assign stable_q[gi] = bit_q;
      assign stable_d[gi] = bit_d;
    end
  endgenerate

  always_comb begin
    warm_d  = warm_q;
    valid_d = valid_q | (warm_q == WARM_LAST);
    if (!valid_q && (warm_q != WARM_LAST)) begin
      warm_d = warm_q + WW'(1);
    end
  end

  // Counting needs 00 both before and after the edge, so a debounced change
  // clears the timer (and line_lost) on the very edge it lands.
  always_comb begin
    timer_d = '0;
    if ((stable_d == 2'b00) && (stable_q == 2'b00) && valid_q) begin
      timer_d = (timer_q == LOST_MAX) ? timer_q : timer_q + LW'(1);
    end
    lost_d = (timer_d == LOST_MAX);
  end

`ifdef IR_LAST_SIDE_HOLD_EN
  logic [1:0] last_q, last_d;

  always_comb begin
    last_d   = (stable_d != 2'b00) ? stable_d : last_q;
    out_d    = lost_d ? last_d : stable_d;
    // Entering hold swaps 00 for the remembered side silently.
    change_d = (out_d != out_q) && !(lost_d && !lost_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= 2'b00;
    end else begin
      last_q <= last_d;
    end
  end
`else
  always_comb begin
    out_d    = stable_d;
    change_d = (out_d != out_q);
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      warm_q   <= '0;
      valid_q  <= 1'b0;
      timer_q  <= '0;
      lost_q   <= 1'b0;
      out_q    <= 2'b00;
      change_q <= 1'b0;
    end else begin
      warm_q   <= warm_d;
      valid_q  <= valid_d;
      timer_q  <= timer_d;
      lost_q   <= lost_d;
      out_q    <= out_d;
      change_q <= change_d;
    end
  end

  assign ir_sensor_data = out_q;
  assign data_valid     = valid_q;
  assign change_pulse   = change_q;
  assign line_lost      = lost_q;

endmodule

// File: tb/tb_ir_sensor_conditioner.sv
// Directed bench for ir_sensor_conditioner with DEBOUNCE_CYCLES=4, LOST_TIMEOUT=20.
module tb_ir_sensor_conditioner;

  localparam int DB = 4;
  localparam int LT = 20;
`ifdef IR_LAST_SIDE_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] ir_raw = 2'b00;
  logic [1:0] ir_sensor_data;
  logic       data_valid;
  logic       change_pulse;
  logic       line_lost;

  int n_cmp = 0;
  int n_bad = 0;
  int edge_n = 0;

  ir_sensor_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .LOST_TIMEOUT   (LT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .ir_raw        (ir_raw),
    .ir_sensor_data(ir_sensor_data),
    .data_valid    (data_valid),
    .change_pulse  (change_pulse),
    .line_lost     (line_lost)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  // Reset over one edge, release just after it; the next edge is edge 1.
  task automatic start(input logic [1:0] raw);
    reset  = 1'b1;
    ir_raw = raw;
    @(posedge clk);
    #1;
    reset  = 1'b0;
    edge_n = 0;
  endtask

  task automatic test_reset();
    logic exp_v;
    start(2'b00);
    n_cmp++;
    if ({ir_sensor_data, data_valid, change_pulse, line_lost} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_state: got data=%b v=%b c=%b l=%b want all 0",
               ir_sensor_data, data_valid, change_pulse, line_lost);
    end
    for (int e = 1; e <= 8; e++) begin
      tick();
      exp_v = (edge_n >= DB + 2);
      n_cmp++;
      if (data_valid !== exp_v) begin
        n_bad++;
        $display("FAIL reset_valid edge %0d: got %b want %b", edge_n, data_valid, exp_v);
      end
      n_cmp++;
      if ({ir_sensor_data, change_pulse, line_lost} !== 4'b0) begin
        n_bad++;
        $display("FAIL reset_quiet edge %0d: got data=%b c=%b l=%b want 00/0/0",
                 edge_n, ir_sensor_data, change_pulse, line_lost);
      end
    end
    $display("test_reset: %0d compared so far", n_cmp);
  endtask

  task automatic test_accept();
    logic [1:0] exp_d;
    logic       exp_c;
    start(2'b10);
    for (int e = 1; e <= 8; e++) begin
      tick();
      exp_d = (edge_n >= DB + 2) ? 2'b10 : 2'b00;
      exp_c = (edge_n == DB + 2);
      n_cmp++;
      if (ir_sensor_data !== exp_d) begin
        n_bad++;
        $display("FAIL accept_data edge %0d: got %b want %b", edge_n, ir_sensor_data, exp_d);
      end
      n_cmp++;
      if (change_pulse !== exp_c) begin
        n_bad++;
        $display("FAIL accept_pulse edge %0d: got %b want %b", edge_n, change_pulse, exp_c);
      end
    end
    $display("test_accept: %0d compared so far", n_cmp);
  endtask

  task automatic test_glitch();
    logic [1:0] exp_d;
    logic       exp_c;
    start(2'b00);
    for (int e = 1; e <= 6; e++) tick();
    // 3-on/1-off bursts never reach the acceptance count
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 4; k++) begin
        ir_raw = (k < 3) ? 2'b01 : 2'b00;
        tick();
        n_cmp++;
        if ({ir_sensor_data, change_pulse} !== 3'b000) begin
          n_bad++;
          $display("FAIL glitch_reject burst %0d k %0d: got data=%b c=%b want 00/0",
                   b, k, ir_sensor_data, change_pulse);
        end
      end
    end
    // exactly DEBOUNCE_CYCLES on is accepted, then 00 is re-accepted
    for (int k = 0; k <= 10; k++) begin
      ir_raw = (k < DB) ? 2'b01 : 2'b00;
      tick();
      exp_d = (k >= 5 && k <= 8) ? 2'b01 : 2'b00;
      exp_c = (k == 5) || (k == 9);
      n_cmp++;
      if (ir_sensor_data !== exp_d) begin
        n_bad++;
        $display("FAIL glitch_min_data k %0d: got %b want %b", k, ir_sensor_data, exp_d);
      end
      n_cmp++;
      if (change_pulse !== exp_c) begin
        n_bad++;
        $display("FAIL glitch_min_pulse k %0d: got %b want %b", k, change_pulse, exp_c);
      end
    end
    $display("test_glitch: %0d compared so far", n_cmp);
  endtask

  // Debounced first->00 at edge 14, lost at 34, 01 accepted at 41,
  // 00 again at 48, then 10 lands at 68 exactly when the timer would expire.
  task automatic test_line_lost(input logic [1:0] first);
    logic [1:0] exp_d;
    logic       exp_c, exp_l, exp_v;
    int         e;
    start(first);
    for (int i = 1; i <= 70; i++) begin
      tick();
      e = edge_n;
      if (e < 8)       ir_raw = first;
      else if (e < 35) ir_raw = 2'b00;
      else if (e < 42) ir_raw = 2'b01;
      else if (e < 62) ir_raw = 2'b00;
      else             ir_raw = 2'b10;
      if (e < 6)       exp_d = 2'b00;
      else if (e < 14) exp_d = first;
      else if (e < 34) exp_d = 2'b00;
      else if (e < 41) exp_d = HOLD ? first : 2'b00;
      else if (e < 48) exp_d = 2'b01;
      else if (e < 68) exp_d = 2'b00;
      else             exp_d = 2'b10;
      exp_c = (e == 6) || (e == 14) || (e == 48) || (e == 68) ||
              ((e == 41) && !(HOLD && first == 2'b01));
      exp_l = (e >= 34) && (e <= 40);
      exp_v = (e >= 6);
      n_cmp++;
      if (ir_sensor_data !== exp_d) begin
        n_bad++;
        $display("FAIL lost_data first=%b edge %0d: got %b want %b", first, e, ir_sensor_data, exp_d);
      end
      n_cmp++;
      if (change_pulse !== exp_c) begin
        n_bad++;
        $display("FAIL lost_pulse first=%b edge %0d: got %b want %b", first, e, change_pulse, exp_c);
      end
      n_cmp++;
      if (line_lost !== exp_l) begin
        n_bad++;
        $display("FAIL lost_flag first=%b edge %0d: got %b want %b", first, e, line_lost, exp_l);
      end
      n_cmp++;
      if (data_valid !== exp_v) begin
        n_bad++;
        $display("FAIL lost_valid first=%b edge %0d: got %b want %b", first, e, data_valid, exp_v);
      end
    end
    $display("test_line_lost first=%b: %0d compared so far", first, n_cmp);
  endtask

  task automatic test_reset_mid();
    logic [1:0] exp_d;
    logic       exp_v, exp_c;
    start(2'b00);
    for (int e = 1; e <= 7; e++) tick();
    ir_raw = 2'b11;
    for (int e = 8; e <= 12; e++) tick();
    n_cmp++;
    if ({ir_sensor_data, data_valid} !== 3'b001) begin
      n_bad++;
      $display("FAIL mid_pending: got data=%b v=%b want 00/1", ir_sensor_data, data_valid);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({ir_sensor_data, data_valid, change_pulse, line_lost} !== 5'b0) begin
      n_bad++;
      $display("FAIL mid_async_reset: got data=%b v=%b c=%b l=%b want all 0",
               ir_sensor_data, data_valid, change_pulse, line_lost);
    end
    @(posedge clk);
    #1;
    reset  = 1'b0;
    edge_n = 0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      exp_v = (edge_n >= DB + 2);
      exp_d = exp_v ? 2'b11 : 2'b00;
      exp_c = (edge_n == DB + 2);
      n_cmp++;
      if (data_valid !== exp_v) begin
        n_bad++;
        $display("FAIL mid_valid edge %0d: got %b want %b", edge_n, data_valid, exp_v);
      end
      n_cmp++;
      if (ir_sensor_data !== exp_d) begin
        n_bad++;
        $display("FAIL mid_data edge %0d: got %b want %b", edge_n, ir_sensor_data, exp_d);
      end
      n_cmp++;
      if (change_pulse !== exp_c) begin
        n_bad++;
        $display("FAIL mid_pulse edge %0d: got %b want %b", edge_n, change_pulse, exp_c);
      end
    end
    $display("test_reset_mid: %0d compared so far", n_cmp);
  endtask

  initial begin
    test_reset();
    test_accept();
    test_glitch();
    test_line_lost(2'b11);
    test_line_lost(2'b10);
    test_line_lost(2'b01);
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ir_sensor_conditioner.md
Name: ir_sensor_conditioner

Overview:
- Upstream front end for the line-following core. Takes the raw 2-bit IR reflectance inputs and synchronises them to clk, then debounces each channel independently.
- Drives the clean ir_sensor_data bus consumed by the position / line-following / PWM top level.
- Also reports data validity, a change strobe, and a line-lost timeout so the controller can react when both sensors stay off the line.

Parameters:
- DEBOUNCE_CYCLES, 1000: consecutive cycles a synchronised level must differ from the debounced value before it is accepted. Legal range ≥ 2.
- LOST_TIMEOUT, 50000: cycles of debounced 2'b00, with data_valid high, before line_lost asserts. Legal range ≥ 1.
- Counter widths are derived: $clog2(DEBOUNCE_CYCLES+1) and $clog2(LOST_TIMEOUT+1).

Ports:
- clk  input  1  system clock; the block's only clock.
- reset  input  1  asynchronous, active-high reset.
- ir_raw  input  2  raw sensor pins, asynchronous to clk. Bit1 = left, bit0 = right; 1 = line detected.
- ir_sensor_data  output  2  debounced sensor value, registered.
- data_valid  output  1  high once the warm-up period after reset has completed.
- change_pulse  output  1  one-cycle strobe in the cycle ir_sensor_data takes a new value.
- line_lost  output  1  high while the line has been missing for ≥ LOST_TIMEOUT cycles.

Behaviour:
- Reset (async, immediate):
  - ir_sensor_data = 2'b00; data_valid = 0; change_pulse = 0; line_lost = 0.
  - Synchroniser flops, debounce counters, warm-up counter and lost timer all clear to 0.
  - Reset asserted mid-debounce or mid-timeout discards all progress. There is no partial carry-over.
- Synchroniser: two flops per bit (s1, s2). Debounce logic sees s2 only.
- Debounce, per channel, independent:
  - If s2 == stable bit: counter clears to 0.
  - Otherwise the counter increments.
  - On the edge where the counter value is DEBOUNCE_CYCLES-1 and the mismatch is still present: stable bit takes s2 and the counter clears.
  - Latency: a raw level held steady from before edge 1 appears on ir_sensor_data at edge DEBOUNCE_CYCLES+2.
  - Glitch rejection: any return to the stable level before acceptance resets the count. Pulses shorter than DEBOUNCE_CYCLES are never passed.
  - Both channels changing together are accepted on the same edge when their timing matches, giving a single change_pulse.
- change_pulse: registered. High for exactly one cycle, coincident with the first cycle of any new ir_sensor_data value.
- data_valid:
  - Warm-up counter runs from reset release.
  - data_valid rises at edge DEBOUNCE_CYCLES+2 after reset deassertion and stays high until the next reset.
  - ir_sensor_data is meaningful only while data_valid = 1.
- Lost timer:
  - Increments each cycle the debounced value == 2'b00 and data_valid = 1. Saturates at LOST_TIMEOUT.
  - Clears on any cycle the debounced value != 2'b00.
  - line_lost is registered from (next count == LOST_TIMEOUT). If the debounced value becomes 00 at edge E, line_lost rises at edge E+LOST_TIMEOUT.
  - line_lost falls on the same edge the debounced value leaves 00.
  - If a debounced change lands on the edge the timer would expire, the change wins: the timer clears and line_lost stays 0.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: IR_LAST_SIDE_HOLD_EN.
- Defined:
  - While line_lost = 1, ir_sensor_data holds the last non-zero debounced value, so downstream keeps steering toward the side where the line was last seen.
  - A register captures each non-zero debounced value. Its reset value is 2'b00, and 00 is output if no non-zero value has been seen.
  - change_pulse does not fire on entering hold. On leaving hold it fires only if the output value changes.
  - Lost timer and line_lost are unchanged.
- Undefined: ir_sensor_data always equals the internal debounced value. The hold register is absent.

Test Plan:
- Bench parameters: DEBOUNCE_CYCLES=4, LOST_TIMEOUT=20.
- Reset release with ir_raw=00 → all outputs 0. data_valid rises at edge 6. ir_sensor_data stays 00 with no change_pulse.
- ir_raw 00→10 held from before edge 1 → ir_sensor_data=10 and change_pulse=1 at edge 6 only; cycle 7 change_pulse=0.
- ir_raw=01 for 3 cycles, then back to 00 → ir_sensor_data stays 00 and no change_pulse. Repeating 3-on/1-off bursts never pass.
- Debounced 11→00 at edge E → line_lost rises at E+20. ir_raw→01 then gives ir_sensor_data=01 and line_lost=0 on the same edge. Retiming so the change lands at exactly E+20 keeps line_lost=0.
- Assert reset at count 3 of a pending 00→11 debounce → outputs 0 immediately. After release with ir_raw=11, data_valid and ir_sensor_data=11 both appear at edge 6.
- IR_LAST_SIDE_HOLD_EN defined: debounced 10 then 00 for 20 cycles → line_lost=1 and ir_sensor_data=10, with no change_pulse on entry. Debounced 01 next → output 01, change_pulse=1, line_lost=0.
